// File: rtl/sc_inst_enc_if.sv
// Request channel of the instruction encoder: one symbolic instruction per
// valid/ready handshake, driven by the harness (master) into the loader (slave).
interface sc_inst_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;

    modport master (
        output in_valid, mnem, rs, rt, rd, sa, imm, target, last,
        input  in_ready
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, sa, imm, target, last,
        output in_ready
    );
endinterface

// File: rtl/sc_inst_enc.sv
// Instruction encoder / imem program loader: packs symbolic requests into MIPS
// words and writes them sequentially. Optional running checksum: SC_INST_ENC_CHECKSUM_EN.
module sc_inst_enc #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    localparam int         ADDR_W    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    sc_inst_enc_if.slave      req,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              err,
    output logic              done
`ifdef SC_INST_ENC_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [31:0]       count_ext;
    logic              accept;

    // Fields a mnemonic does not use are replaced by zeros, never merged in.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (req.mnem)
            5'd0:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h20};
            5'd1:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h22};
            5'd2:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h24};
            5'd3:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h25};
            5'd4:  enc_word = {6'h00, req.rs, req.rt, req.rd, 5'd0, 6'h26};
            5'd5:  enc_word = {6'h00, 5'd0, req.rt, req.rd, req.sa, 6'h00};
            5'd6:  enc_word = {6'h00, 5'd0, req.rt, req.rd, req.sa, 6'h02};
            5'd7:  enc_word = {6'h00, 5'd0, req.rt, req.rd, req.sa, 6'h03};
            5'd8:  enc_word = {6'h00, req.rs, 15'd0, 6'h08};
            5'd9:  enc_word = {6'h08, req.rs, req.rt, req.imm};
            5'd10: enc_word = {6'h0C, req.rs, req.rt, req.imm};
            5'd11: enc_word = {6'h0D, req.rs, req.rt, req.imm};
            5'd12: enc_word = {6'h0E, req.rs, req.rt, req.imm};
            5'd13: enc_word = {6'h23, req.rs, req.rt, req.imm};
            5'd14: enc_word = {6'h2B, req.rs, req.rt, req.imm};
            5'd15: enc_word = {6'h04, req.rs, req.rt, req.imm};
            5'd16: enc_word = {6'h05, req.rs, req.rt, req.imm};
            5'd17: enc_word = {6'h0F, 5'd0, req.rt, req.imm};
            5'd18: enc_word = {6'h02, req.target};
            5'd19: enc_word = {6'h03, req.target};
            default: enc_legal = 1'b0;
        endcase
    end

    assign count_ext    = 32'(count_q);
    assign full         = (count_q == ADDR_W'(DEPTH));
    assign req.in_ready = (state_q == IDLE) & ~full & ~done_q;
    assign accept       = req.in_valid & req.in_ready;

`ifdef SC_INST_ENC_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic [4:0]  rot_amt;
    logic [31:0] rot_word;

    assign rot_amt  = count_ext[4:0];
    assign rot_word = (data_q << rot_amt) | (data_q >> (6'd32 - {1'b0, rot_amt}));
`endif

    // start wins over a pending commit; a WRITE cycle always commits otherwise.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = done_q;
`ifdef SC_INST_ENC_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (start) begin
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
`ifdef SC_INST_ENC_CHECKSUM_EN
            csum_d  = 32'h0;
`endif
        end else if (state_q == WRITE) begin
            state_d = IDLE;
            count_d = count_q + ADDR_W'(1);
            if (last_q) begin
                done_d = 1'b1;
            end
`ifdef SC_INST_ENC_CHECKSUM_EN
            csum_d  = csum_q ^ rot_word;
`endif
        end else if (accept) begin
            if (enc_legal) begin
                data_d  = enc_word;
                last_d  = req.last;
                state_d = WRITE;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= 32'h0;
            last_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef SC_INST_ENC_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= 32'h0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

    assign imem_we   = (state_q == WRITE);
    assign imem_addr = BASE_ADDR + (count_ext << 2);
    assign imem_data = data_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sc_inst_enc.sv
// Directed bench for sc_inst_enc (DEPTH = 4, BASE_ADDR = 0) with hand-computed
// instruction words; start is used between scenarios to rewind the loader.
module tb_sc_inst_enc;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_data;
    logic [ADDR_W-1:0] count;
    logic              full;
    logic              err;
    logic              done;
`ifdef SC_INST_ENC_CHECKSUM_EN
    logic [31:0]       csum;
`endif

    int checks = 0;
    int errors = 0;

    int          wr_cnt = 0;
    logic [31:0] wr_addr [128];
    logic [31:0] wr_data [128];

    sc_inst_enc_if req_if ();

    sc_inst_enc #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .req      (req_if.slave),
        .imem_we  (imem_we),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .count    (count),
        .full     (full),
        .err      (err),
        .done     (done)
`ifdef SC_INST_ENC_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    always #5 clock = ~clock;

    // Log every strobed write, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            if (wr_cnt < 128) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_data;
            end
            wr_cnt++;
        end
    end

    // Directed encodings with junk in every irrelevant field.
    logic [4:0]  v_m   [8] = '{5'd1, 5'd7, 5'd8, 5'd17, 5'd15, 5'd18, 5'd4, 5'd14};
    logic [4:0]  v_rs  [8] = '{5'd1, 5'd9, 5'd31, 5'd7, 5'd1, 5'd31, 5'd4, 5'd2};
    logic [4:0]  v_rt  [8] = '{5'd2, 5'd3, 5'd5, 5'd1, 5'd2, 5'd31, 5'd5, 5'd3};
    logic [4:0]  v_rd  [8] = '{5'd3, 5'd2, 5'd6, 5'd9, 5'd17, 5'd31, 5'd6, 5'd21};
    logic [4:0]  v_sa  [8] = '{5'd5, 5'd4, 5'd7, 5'd3, 5'd11, 5'd31, 5'd9, 5'd13};
    logic [15:0] v_imm [8] = '{16'hAAAA, 16'h5555, 16'h1111, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hBEEF, 16'h0010};
    logic [25:0] v_tgt [8] = '{26'h3FFFFFF, 26'h1555555, 26'h2AAAAAA, 26'h3FFFFFF, 26'h3FFFFFF, 26'h0000123, 26'h3FFFFFF, 26'h3FFFFFF};
    logic [31:0] v_exp [8] = '{32'h00221822, 32'h00031103, 32'h03E00008, 32'h3C011234,
                               32'h1022FFFF, 32'h08000123, 32'h00853026, 32'hAC430010};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic lst);
        req_if.in_valid = 1'b1;
        req_if.mnem     = m;
        req_if.rs       = rs;
        req_if.rt       = rt;
        req_if.rd       = rd;
        req_if.sa       = sa;
        req_if.imm      = imm;
        req_if.target   = tgt;
        req_if.last     = lst;
    endtask

    task automatic idle_bus();
        req_if.in_valid = 1'b0;
        req_if.last     = 1'b0;
    endtask

    task automatic do_start();
        idle_bus();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        idle_bus();
        send(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        idle_bus();
        #2;
        checks++; if (req_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", req_if.in_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", imem_we); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 00000000", imem_addr); end
        checks++; if (imem_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 00000000", imem_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        checks++; if ({full, err, done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {full, err, done}); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_add();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        checks++; if (req_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready got %b want 1", req_if.in_ready); end
        step();
        idle_bus();
        checks++; if (imem_we !== 1'b1) begin errors++; $display("[TB] FAIL add_we got %b want 1", imem_we); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL add_addr got %h want 00000000", imem_addr); end
        checks++; if (imem_data !== 32'h00221820) begin errors++; $display("[TB] FAIL add_data got %h want 00221820", imem_data); end
        checks++; if (req_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL add_write_ready got %b want 0", req_if.in_ready); end
        step();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL add_we_drop got %b want 0", imem_we); end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL add_count got %0d want 1", count); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL add_next_addr got %h want 00000004", imem_addr); end
    endtask

    task automatic test_back_to_back();
        do_start();
        send(5'd5, 5'd9, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
        step();
        send(5'd13, 5'd29, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0);
        checks++; if (imem_data !== 32'h00031100) begin errors++; $display("[TB] FAIL sll_data got %h want 00031100", imem_data); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL sll_addr got %h want 00000000", imem_addr); end
        checks++; if (req_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL sll_write_ready got %b want 0", req_if.in_ready); end
        step();
        checks++; if ({imem_we, req_if.in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_idle we,ready got %b want 01", {imem_we, req_if.in_ready}); end
        step();
        idle_bus();
        checks++; if (imem_we !== 1'b1) begin errors++; $display("[TB] FAIL lw_we got %b want 1", imem_we); end
        checks++; if (imem_data !== 32'h8FA40008) begin errors++; $display("[TB] FAIL lw_data got %h want 8FA40008", imem_data); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL lw_addr got %h want 00000004", imem_addr); end
        checks++; if (req_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL lw_write_ready got %b want 0", req_if.in_ready); end
        step();
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", count); end
    endtask

    task automatic test_last();
        int base;
        do_start();
        send(5'd19, 5'd3, 5'd3, 5'd3, 5'd3, 16'h3333, 26'h0000010, 1'b1);
        step();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        checks++; if (imem_data !== 32'h0C000010) begin errors++; $display("[TB] FAIL jal_data got %h want 0C000010", imem_data); end
        step();
        base = wr_cnt;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL jal_done got %b want 1", done); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (req_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL done_ready got %b want 0", req_if.in_ready); end
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL done_count got %0d want 1", count); end
        checks++; if (wr_cnt !== base) begin errors++; $display("[TB] FAIL done_no_write got %0d writes want 0", wr_cnt - base); end
        idle_bus();
    endtask

    task automatic test_illegal();
        do_start();
        send(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h1, 1'b0);
        step();
        idle_bus();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b want 1", err); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL illegal_we got %b want 0", imem_we); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL illegal_count got %0d want 0", count); end
        send(5'd11, 5'd0, 5'd5, 5'd7, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        step();
        idle_bus();
        checks++; if (imem_data !== 32'h3405FFFF) begin errors++; $display("[TB] FAIL ori_data got %h want 3405FFFF", imem_data); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL ori_addr got %h want 00000000", imem_addr); end
        step();
        checks++; if ({err, count} !== {1'b1, 3'd1}) begin errors++; $display("[TB] FAIL ori_err_count got %b want 1001", {err, count}); end
    endtask

    task automatic test_encodings();
        for (int i = 0; i < 8; i++) begin
            do_start();
            send(v_m[i], v_rs[i], v_rt[i], v_rd[i], v_sa[i], v_imm[i], v_tgt[i], 1'b0);
            step();
            idle_bus();
            checks++; if (imem_we !== 1'b1 || imem_data !== v_exp[i]) begin errors++; $display("[TB] FAIL enc%0d we,data got %b %h want 1 %h", i, imem_we, imem_data, v_exp[i]); end
            step();
        end
    endtask

    task automatic test_full();
        int base;
        int req_i;
        int accepted;
        logic hit;
        do_start();
        base     = wr_cnt;
        req_i    = 0;
        accepted = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (req_i < 6) send(v_m[req_i], v_rs[req_i], v_rt[req_i], v_rd[req_i], v_sa[req_i],
                                v_imm[req_i], v_tgt[req_i], 1'b0);
            hit = req_if.in_valid && req_if.in_ready;
            step();
            if (hit) begin
                accepted++;
                req_i++;
            end
        end
        checks++; if (accepted !== 4) begin errors++; $display("[TB] FAIL full_accepted got %0d want 4", accepted); end
        checks++; if (wr_cnt - base !== 4) begin errors++; $display("[TB] FAIL full_writes got %0d want 4", wr_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_addr[base+i] !== 32'(4 * i) || wr_data[base+i] !== v_exp[i]) begin
                errors++; $display("[TB] FAIL full_wr%0d addr,data got %h %h want %h %h", i, wr_addr[base+i], wr_data[base+i], 32'(4 * i), v_exp[i]);
            end
        end
        checks++; if ({full, count} !== {1'b1, 3'd4}) begin errors++; $display("[TB] FAIL full_flag_count got %b want 1100", {full, count}); end
        checks++; if (req_if.in_ready !== 1'b0 || req_if.in_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_stall ready,valid got %b%b want 01", req_if.in_ready, req_if.in_valid); end
        idle_bus();
    endtask

    task automatic test_start_abort();
        do_start();
        send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        step();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        step();
        idle_bus();
        step();
        send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        step();
        idle_bus();
        checks++; if ({imem_we, err, count} !== {1'b1, 1'b1, 3'd1}) begin errors++; $display("[TB] FAIL abort_pre we,err,count got %b want 11001", {imem_we, err, count}); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_we got %b want 0", imem_we); end
        checks++; if ({count, err, done} !== 5'b00000) begin errors++; $display("[TB] FAIL abort_clear count,err,done got %b want 00000", {count, err, done}); end
        send(5'd11, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        step();
        idle_bus();
        checks++; if (imem_addr !== 32'h0 || imem_data !== 32'h3405FFFF) begin errors++; $display("[TB] FAIL abort_next addr,data got %h %h want 00000000 3405FFFF", imem_addr, imem_data); end
        step();
    endtask

    task automatic test_reset_mid_write();
        do_start();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        step();
        idle_bus();
        #1;
        reset = 1'b1;
        #1;
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_we got %b want 0", imem_we); end
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++; if (count !== 3'd0 || imem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid count,we got %0d %b want 0 0", count, imem_we); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_last();
        test_illegal();
        test_encodings();
        test_full();
        test_start_abort();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
